// File: rtl/fifo_bank_pkg.sv
// fifo_bank_pkg: shared helpers for the FIFO bank.
//   calc_cw    - width of an occupancy counter able to hold 0..depth.
//   ptr_width  - width of a read/write pointer indexing 0..depth-1.
//   next_ptr   - pointer increment with explicit wrap from depth-1 to 0,
//                so any depth works, not only powers of two.
package fifo_bank_pkg;

    function automatic int calc_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_lane.sv
// fifo_lane: one synchronous FIFO lane.
//   clk, rst      - clock and synchronous active-high reset.
//   wr_en, i_data - write request and data; accepted when not full, or when
//                   full but a read is accepted in the same cycle.
//   rd_en, o_data - read request and data; FWFT=0 gives data the cycle after
//                   an accepted read, FWFT=1 shows the head entry while non-empty.
//   flush         - synchronous clear of pointers, count, error flags, o_data.
//   full, empty, almost_full, almost_empty - occupancy flags.
//   overflow, underflow - sticky: write dropped / read on empty.
//   count         - current occupancy, 0..DEPTH.
module fifo_lane
    import fifo_bank_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CW        = calc_cw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [CW-1:0]         count
);

    localparam int PW = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  clear;

    // Flags come straight from the registered count, so they move one cycle
    // after the write/read that changed it.
    assign full         = (int'(count) == DEPTH);
    assign empty        = (count == '0);
    assign almost_full  = (int'(count) >= AF_THRESH);
    assign almost_empty = (int'(count) <= AE_THRESH);

    // A full lane still takes a write when a read frees a slot this cycle;
    // an empty lane never passes write data straight through.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Reset and flush have the same effect on this lane's state.
    assign clear = rst | flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wptr <= PW'(next_ptr(int'(wptr), DEPTH));
            if (rd_ok) rptr <= PW'(next_ptr(int'(rptr), DEPTH));
            count <= count + CW'(wr_ok) - CW'(rd_ok);
            if (wr_en && !wr_ok) overflow  <= 1'b1;
            if (rd_en && empty)  underflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // entries are valid, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (wr_ok && !clear) mem[wptr] <= i_data;
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is visible whenever the lane holds data.
        assign o_data = empty ? '0 : mem[rptr];
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rdata_q;

        // On a full-lane read+write the write targets the slot being read;
        // the read still returns the old entry because mem updates after the edge.
        always_ff @(posedge clk) begin
            if (clear)      rdata_q <= '0;
            else if (rd_ok) rdata_q <= mem[rptr];
        end

        assign o_data = rdata_q;
    end

endmodule

// File: rtl/fifo_bank.sv
// fifo_bank: NUM_CH independent FIFO lanes sharing clk and rst.
//   clk, rst              - clock and synchronous active-high reset.
//   wr_en, rd_en, flush   - per-lane controls, bit i drives lane i.
//   i_data, o_data        - lane i at [i*DATA_WIDTH +: DATA_WIDTH].
//   full, empty, almost_full, almost_empty, overflow, underflow - per-lane flags.
//   count                 - lane i occupancy at [i*CW +: CW].
module fifo_bank
    import fifo_bank_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 1,
    parameter int AE_THRESH  = 1,
    localparam int CW        = calc_cw(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            wr_en,
    input  logic [NUM_CH-1:0]            rd_en,
    input  logic [NUM_CH-1:0]            flush,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_data,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_data,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH-1:0]            almost_full,
    output logic [NUM_CH-1:0]            almost_empty,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH-1:0]            underflow,
    output logic [NUM_CH*CW-1:0]         count
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        fifo_lane #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .FWFT       (FWFT),
            .AF_THRESH  (AF_THRESH),
            .AE_THRESH  (AE_THRESH)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .wr_en        (wr_en[i]),
            .rd_en        (rd_en[i]),
            .flush        (flush[i]),
            .i_data       (i_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_data       (o_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .full         (full[i]),
            .empty        (empty[i]),
            .almost_full  (almost_full[i]),
            .almost_empty (almost_empty[i]),
            .overflow     (overflow[i]),
            .underflow    (underflow[i]),
            .count        (count[i*CW +: CW])
        );
    end

endmodule

// File: doc/fifo_bank.md
Name: fifo_bank

Overview:
- Bank of NUM_CH independent synchronous FIFO lanes sharing one clock and reset. Each lane has its own handshake, flags and occupancy count.
- Feeds per-row/per-column operand streams into the datapath (e.g. matrix-vector engine); one lane per stream.
- Generalises the single FIFO:
  - any DEPTH (not just powers of two);
  - selectable first-word-fall-through (FWFT) or registered-read mode;
  - programmable almost-full/almost-empty thresholds;
  - pass-through write when full;
  - sticky overflow/underflow error flags;
  - per-lane synchronous flush.

Parameters:
- NUM_CH, 4, number of independent lanes (>=1).
- DEPTH, 8, entries per lane (>=2, any integer).
- DATA_WIDTH, 8, bits per entry.
- FWFT, 0, 0 = registered read (data one cycle after accepted rd_en); 1 = head entry visible on o_data while non-empty.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  NUM_CH  per-lane write request.
- rd_en  in  NUM_CH  per-lane read request.
- flush  in  NUM_CH  per-lane synchronous clear.
- i_data  in  NUM_CH*DATA_WIDTH  write data, lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- o_data  out  NUM_CH*DATA_WIDTH  read data, same packing.
- full  out  NUM_CH  count == DEPTH.
- empty  out  NUM_CH  count == 0.
- almost_full  out  NUM_CH  count >= AF_THRESH.
- almost_empty  out  NUM_CH  count <= AE_THRESH.
- overflow  out  NUM_CH  sticky: write dropped.
- underflow  out  NUM_CH  sticky: read on empty.
- count  out  NUM_CH*CW  occupancy, CW = $clog2(DEPTH+1).

Behaviour:
- Reset: all lanes have pointers = 0 and count = 0.
  - o_data = 0, overflow = 0, underflow = 0.
  - empty = 1, full = 0, almost_empty = 1; almost_full = (AF_THRESH == 0).
- Pointers wrap explicitly from DEPTH-1 to 0. No reliance on power-of-two overflow.
- rd_ok = rd_en & !empty.
- wr_ok = wr_en & (!full | rd_ok). Writing into a full lane is allowed in the same cycle as an accepted read.
- count next = count + wr_ok - rd_ok. Count never exceeds DEPTH and never goes below 0.
- wr_en & !wr_ok: data dropped, storage unchanged, overflow <= 1.
- rd_en & empty: no state change except underflow <= 1. A write in the same cycle is still accepted. Empty lanes never pass data through.
- FWFT=0:
  - o_data <= mem[rptr] on rd_ok, visible the cycle after the accepted read.
  - o_data holds its value otherwise.
- FWFT=1:
  - o_data = mem[rptr] combinationally whenever !empty; o_data = 0 when empty.
  - rd_ok pops the entry; the next entry appears the following cycle.
  - A write to an empty lane is visible on o_data the cycle after the write.
- Flag timing: all flags and count are registered-state derived and update the cycle after the causing event.
- flush[i] priority: over wr_en/rd_en of lane i in the same cycle.
  - Effect: pointers, count, overflow, underflow and o_data reset to their reset values.
  - Any write that cycle is discarded and does not set overflow.
- rst has priority over flush.
- Lanes are fully independent; activity on one lane never affects another.
- Memory contents are not reset; only pointers, count and flags are.

Decomposition:
- Package fifo_bank_pkg holds:
  - localparam helper function for CW (clog2 of DEPTH+1);
  - pointer-increment-with-wrap function.
- Sub-module fifo_lane: one lane with the same parameters minus NUM_CH. fifo_bank is a generate loop of NUM_CH fifo_lane instances plus port slicing.

Test Plan (NUM_CH=2, DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1, both FWFT values):
- Fill lane 0 with 0x10..0x14, then write 0x15 -> full[0]=1, count=5, overflow[0]=1. Drain -> 0x10..0x14 in order; lane 1 count stays 0.
- Wrap test:
  - repeat 3 rounds of write 3 / read 3 on lane 1 with 0xA0+n -> data order intact across pointer wrap 4->0;
  - empty[1]=1 at end, underflow[1]=0.
- Lane 0 full, assert wr_en(0x55) and rd_en together -> oldest popped, 0x55 accepted, count stays 5, overflow unchanged.
- Read on empty lane 1 with simultaneous write 0x77 -> underflow[1]=1, count=1. FWFT=1: o_data lane 1 = 0x77 next cycle. FWFT=0: o_data unchanged.
- Thresholds: count 0->5 -> almost_empty high at counts 0,1; almost_full high at counts 4,5; flags change one cycle after each write.
- Flush lane 0 at count 3 with concurrent wr_en -> count=0, empty=1, flags/o_data = 0. Lane 1 state unaffected. rst mid-stream -> all lanes return to reset values.
